servisia_sram_arbiter: RTL and testbench

- Shares the single external async 8-bit SRAM (16 KiB, 14-bit address) between two requesters: the CPU memory port and a program-loader/debug port.
- Sequences each access into setup / strobe / hold phases on CS_N, WE_N and OE_N, and drives the bidirectional data bus enable.
- Sits between the core-side memory interface and the SRAM pin wrapper. It replaces direct CPU-to-SRAM wiring so the bench and hardware loader can write program images through the same pins.

---
 rtl/servisia_sram_pkg.sv | 25 ++
 rtl/servisia_sram_arbiter_if.sv | 23 ++
 rtl/servisia_rr_arb2.sv | 45 ++++
 rtl/servisia_sram_arbiter.sv | 137 +++++++++++++
 tb/tb_servisia_sram_arbiter.sv | 257 +++++++++++++++++++++++++
 5 files changed

// File: rtl/servisia_sram_pkg.sv
// Shared types and default widths for the SRAM arbiter slice.
package servisia_sram_pkg;

    localparam int unsigned SRAM_ADDR_W = 14;
    localparam int unsigned SRAM_DATA_W = 8;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        STROBE = 2'd2,
        HOLD   = 2'd3
    } sram_state_e;

    typedef enum logic {
        REQ_CPU = 1'b0,
        REQ_LDR = 1'b1
    } req_id_e;

    typedef struct packed {
        logic                   we;
        logic [SRAM_ADDR_W-1:0] addr;
        logic [SRAM_DATA_W-1:0] wdata;
    } sram_req_t;

endpackage

// File: rtl/servisia_sram_arbiter_if.sv
// Requester-side memory port: request fields, one-cycle grant, read-data return.
interface servisia_sram_arbiter_if #(
    parameter int unsigned ADDR_W = servisia_sram_pkg::SRAM_ADDR_W,
    parameter int unsigned DATA_W = servisia_sram_pkg::SRAM_DATA_W
);
    logic              req;
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic              gnt;
    logic              rvalid;
    logic [DATA_W-1:0] rdata;

    modport master (
        output req, we, addr, wdata,
        input  gnt, rvalid, rdata
    );

    modport slave (
        input  req, we, addr, wdata,
        output gnt, rvalid, rdata
    );
endinterface

// File: rtl/servisia_rr_arb2.sv
// Two-way round-robin picker (CPU vs loader) with a loader lock override.
module servisia_rr_arb2
    import servisia_sram_pkg::*;
(
    input  logic clk_i,
    input  logic rst_ni,
    input  logic en_i,
    input  logic req_cpu_i,
    input  logic req_ldr_i,
    input  logic lock_i,
    output logic gnt_cpu_o,
    output logic gnt_ldr_o
);

    req_id_e last_q;

    // Pick a winner; on contention the side not granted last goes first.
    always_comb begin
        gnt_cpu_o = 1'b0;
        gnt_ldr_o = 1'b0;
        if (en_i) begin
            if (lock_i) begin
                gnt_ldr_o = req_ldr_i;
            end else if (req_cpu_i && req_ldr_i) begin
                gnt_cpu_o = (last_q == REQ_LDR);
                gnt_ldr_o = (last_q == REQ_CPU);
            end else begin
                gnt_cpu_o = req_cpu_i;
                gnt_ldr_o = req_ldr_i;
            end
        end
    end

    // Remember the most recent winner.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            last_q <= REQ_LDR;
        end else if (gnt_cpu_o) begin
            last_q <= REQ_CPU;
        end else if (gnt_ldr_o) begin
            last_q <= REQ_LDR;
        end
    end

endmodule

// File: rtl/servisia_sram_arbiter.sv
// Shares one async SRAM between the CPU and loader ports, sequencing each
// access as setup / strobe (WAIT_CYCLES) / hold on CS_N, WE_N and OE_N.
// Optional: define SRAM_ARB_LOCK_EN to add ldr_lock_i (loader exclusive lock).
module servisia_sram_arbiter
    import servisia_sram_pkg::*;
#(
    parameter int unsigned ADDR_W      = SRAM_ADDR_W,
    parameter int unsigned DATA_W      = SRAM_DATA_W,
    parameter int unsigned WAIT_CYCLES = 1
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    servisia_sram_arbiter_if.slave cpu,
    servisia_sram_arbiter_if.slave ldr,
`ifdef SRAM_ARB_LOCK_EN
    input  logic                   ldr_lock_i,
`endif
    output logic                   sram_cs_no,
    output logic                   sram_we_no,
    output logic                   sram_oe_no,
    output logic [ADDR_W-1:0]      sram_addr_o,
    output logic [DATA_W-1:0]      sram_data_o,
    output logic                   sram_data_oe_o,
    input  logic [DATA_W-1:0]      sram_data_i
);

    localparam logic [1:0] ST_IDLE   = IDLE;
    localparam logic [1:0] ST_SETUP  = SETUP;
    localparam logic [1:0] ST_STROBE = STROBE;
    localparam logic [1:0] ST_HOLD   = HOLD;

    logic [1:0]        state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;
    sram_req_t         req_q, req_d;
    req_id_e           owner_q, owner_d;
    logic [DATA_W-1:0] cpu_rdata_q, ldr_rdata_q;

    logic gnt_cpu, gnt_ldr, lock, capture;

`ifdef SRAM_ARB_LOCK_EN
    assign lock = ldr_lock_i;
`else
    assign lock = 1'b0;
`endif

    // Grants only happen in IDLE and never while reset is held.
    servisia_rr_arb2 u_arb (
        .clk_i     (clk_i),
        .rst_ni    (rst_ni),
        .en_i      ((state_q == ST_IDLE) && rst_ni),
        .req_cpu_i (cpu.req),
        .req_ldr_i (ldr.req),
        .lock_i    (lock),
        .gnt_cpu_o (gnt_cpu),
        .gnt_ldr_o (gnt_ldr)
    );

    // Access sequencer: latch the winner in IDLE, then step through the phases.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        req_d   = req_q;
        owner_d = owner_q;
        unique case (state_q)
            ST_IDLE: begin
                if (gnt_cpu) begin
                    req_d   = '{we: cpu.we, addr: cpu.addr, wdata: cpu.wdata};
                    owner_d = REQ_CPU;
                    state_d = ST_SETUP;
                end else if (gnt_ldr) begin
                    req_d   = '{we: ldr.we, addr: ldr.addr, wdata: ldr.wdata};
                    owner_d = REQ_LDR;
                    state_d = ST_SETUP;
                end
            end
            ST_SETUP: begin
                cnt_d   = 4'(WAIT_CYCLES - 1);
                state_d = ST_STROBE;
            end
            ST_STROBE: begin
                if (cnt_q == '0) begin
                    state_d = ST_HOLD;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            ST_HOLD: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Read data is sampled on the final strobe edge while OE_N is still low.
    assign capture = (state_q == ST_STROBE) && (cnt_q == '0) && !req_q.we;

    // State, latched request and per-port read-data registers.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            req_q       <= '0;
            owner_q     <= REQ_LDR;
            cpu_rdata_q <= '0;
            ldr_rdata_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            req_q   <= req_d;
            owner_q <= owner_d;
            if (capture && owner_q == REQ_CPU) begin
                cpu_rdata_q <= sram_data_i;
            end
            if (capture && owner_q == REQ_LDR) begin
                ldr_rdata_q <= sram_data_i;
            end
        end
    end

    // Pin strobes decode from state alone, so WE_N and OE_N can never overlap.
    assign sram_cs_no     = (state_q == ST_IDLE);
    assign sram_we_no     = !((state_q == ST_STROBE) && req_q.we);
    assign sram_oe_no     = !((state_q == ST_STROBE) && !req_q.we);
    assign sram_addr_o    = req_q.addr;
    assign sram_data_o    = req_q.wdata;
    assign sram_data_oe_o = (state_q != ST_IDLE) && req_q.we;

    assign cpu.gnt    = gnt_cpu;
    assign ldr.gnt    = gnt_ldr;
    assign cpu.rvalid = (state_q == ST_HOLD) && !req_q.we && (owner_q == REQ_CPU);
    assign ldr.rvalid = (state_q == ST_HOLD) && !req_q.we && (owner_q == REQ_LDR);
    assign cpu.rdata  = cpu_rdata_q;
    assign ldr.rdata  = ldr_rdata_q;

endmodule

// File: tb/tb_servisia_sram_arbiter.sv
// Directed bench for servisia_sram_arbiter: one instance at WAIT_CYCLES=1 on a
// small SRAM model, a second at WAIT_CYCLES=3 reading a fixed pattern.
module tb_servisia_sram_arbiter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n;
    int   n_checks = 0;
    int   n_errors = 0;

    servisia_sram_arbiter_if cpu_if ();
    servisia_sram_arbiter_if ldr_if ();
    servisia_sram_arbiter_if cpu3_if ();
    servisia_sram_arbiter_if ldr3_if ();

    logic        cs_n, we_n, oe_n, doe;
    logic [13:0] s_addr;
    logic [7:0]  s_dout, s_din;
    logic        cs3_n, we3_n, oe3_n, doe3;
    logic [13:0] s3_addr;
    logic [7:0]  s3_dout, s3_din;
    logic [7:0]  mem [0:31];

`ifdef SRAM_ARB_LOCK_EN
    logic ldr_lock = 1'b0;
`endif

    always @(posedge clk) begin
        if (!cs_n && !we_n) mem[s_addr[4:0]] <= s_dout;
    end
    assign s_din  = (!cs_n && !oe_n) ? mem[s_addr[4:0]] : 8'h00;
    assign s3_din = (!cs3_n && !oe3_n) ? 8'h3C : 8'h00;

    servisia_sram_arbiter #(.WAIT_CYCLES(1)) dut (
        .clk_i          (clk),
        .rst_ni         (rst_n),
        .cpu            (cpu_if),
        .ldr            (ldr_if),
`ifdef SRAM_ARB_LOCK_EN
        .ldr_lock_i     (ldr_lock),
`endif
        .sram_cs_no     (cs_n),
        .sram_we_no     (we_n),
        .sram_oe_no     (oe_n),
        .sram_addr_o    (s_addr),
        .sram_data_o    (s_dout),
        .sram_data_oe_o (doe),
        .sram_data_i    (s_din)
    );

    servisia_sram_arbiter #(.WAIT_CYCLES(3)) dut3 (
        .clk_i          (clk),
        .rst_ni         (rst_n),
        .cpu            (cpu3_if),
        .ldr            (ldr3_if),
`ifdef SRAM_ARB_LOCK_EN
        .ldr_lock_i     (1'b0),
`endif
        .sram_cs_no     (cs3_n),
        .sram_we_no     (we3_n),
        .sram_oe_no     (oe3_n),
        .sram_addr_o    (s3_addr),
        .sram_data_o    (s3_dout),
        .sram_data_oe_o (doe3),
        .sram_data_i    (s3_din)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    // Starts in an IDLE cycle, ends in the next IDLE cycle.
    task automatic do_write(input bit use_ldr, input logic [13:0] a, input logic [7:0] d);
        if (use_ldr) begin
            ldr_if.req = 1'b1; ldr_if.we = 1'b1; ldr_if.addr = a; ldr_if.wdata = d;
        end else begin
            cpu_if.req = 1'b1; cpu_if.we = 1'b1; cpu_if.addr = a; cpu_if.wdata = d;
        end
        #1;
        check_eq("wr_gnt", use_ldr ? ldr_if.gnt : cpu_if.gnt, 1);
        tick();
        ldr_if.req = 1'b0;
        cpu_if.req = 1'b0;
        repeat (3) tick();
        #1;
    endtask

    initial begin
        rst_n = 1'b0;
        cpu_if.req = 0; cpu_if.we = 0; cpu_if.addr = '0; cpu_if.wdata = '0;
        ldr_if.req = 0; ldr_if.we = 0; ldr_if.addr = '0; ldr_if.wdata = '0;
        cpu3_if.req = 0; cpu3_if.we = 0; cpu3_if.addr = '0; cpu3_if.wdata = '0;
        ldr3_if.req = 0; ldr3_if.we = 0; ldr3_if.addr = '0; ldr3_if.wdata = '0;
        repeat (3) tick();
        #1;

        // Reset state
        check_eq("rst_cs", cs_n, 1);
        check_eq("rst_we", we_n, 1);
        check_eq("rst_oe", oe_n, 1);
        check_eq("rst_doe", doe, 0);
        check_eq("rst_addr", s_addr, 0);
        check_eq("rst_dout", s_dout, 0);
        check_eq("rst_rv", {cpu_if.rvalid, ldr_if.rvalid}, 0);
        check_eq("rst_rdata", {cpu_if.rdata, ldr_if.rdata}, 0);

        // Loader writes 0xA5 to 0x0010
        tick();
        rst_n = 1'b1;
        ldr_if.req = 1; ldr_if.we = 1; ldr_if.addr = 14'h0010; ldr_if.wdata = 8'hA5;
        #1;
        check_eq("w_ldr_gnt", ldr_if.gnt, 1);
        check_eq("w_cpu_gnt", cpu_if.gnt, 0);
        tick(); ldr_if.req = 0; #1;
        check_eq("w_t1_cs", cs_n, 0);
        check_eq("w_t1_we", we_n, 1);
        check_eq("w_t1_oe", oe_n, 1);
        check_eq("w_t1_doe", doe, 1);
        check_eq("w_t1_dout", s_dout, 8'hA5);
        check_eq("w_t1_addr", s_addr, 14'h0010);
        tick(); #1;
        check_eq("w_t2_cs", cs_n, 0);
        check_eq("w_t2_we", we_n, 0);
        check_eq("w_t2_oe", oe_n, 1);
        check_eq("w_t2_doe", doe, 1);
        tick(); #1;
        check_eq("w_t3_cs", cs_n, 0);
        check_eq("w_t3_we", we_n, 1);
        check_eq("w_t3_oe", oe_n, 1);
        check_eq("w_t3_doe", doe, 1);
        check_eq("w_t3_rv", ldr_if.rvalid, 0);
        tick(); #1;
        check_eq("w_t4_cs", cs_n, 1);
        check_eq("w_t4_doe", doe, 0);

        // CPU reads back 0x0010
        cpu_if.req = 1; cpu_if.we = 0; cpu_if.addr = 14'h0010;
        #1;
        check_eq("r_cpu_gnt", cpu_if.gnt, 1);
        check_eq("r_ldr_gnt", ldr_if.gnt, 0);
        tick(); cpu_if.req = 0; #1;
        check_eq("r_t1_oe", oe_n, 1);
        check_eq("r_t1_doe", doe, 0);
        tick(); #1;
        check_eq("r_t2_oe", oe_n, 0);
        check_eq("r_t2_we", we_n, 1);
        tick(); #1;
        check_eq("r_t3_rv", cpu_if.rvalid, 1);
        check_eq("r_t3_rdata", cpu_if.rdata, 8'hA5);
        check_eq("r_t3_ldr_rv", ldr_if.rvalid, 0);
        tick(); #1;
        check_eq("r_t4_rv", cpu_if.rvalid, 0);
        check_eq("r_t4_keep", cpu_if.rdata, 8'hA5);

        // Preload 0x11 at 1 and 0x22 at 2
        do_write(1'b1, 14'h0001, 8'h11);
        do_write(1'b0, 14'h0002, 8'h22);

        // Both request continuously from reset
        rst_n = 1'b0;
        cpu_if.req = 1; cpu_if.we = 0; cpu_if.addr = 14'h0001;
        ldr_if.req = 1; ldr_if.we = 0; ldr_if.addr = 14'h0002;
        #1;
        check_eq("rr_gnt_in_rst", {cpu_if.gnt, ldr_if.gnt}, 0);
        tick();
        rst_n = 1'b1;
        #1;
        for (int i = 0; i < 16; i++) begin
            check_eq("rr_cpu_gnt", cpu_if.gnt, (i % 8) == 0);
            check_eq("rr_ldr_gnt", ldr_if.gnt, (i % 8) == 4);
            check_eq("rr_cpu_rv", cpu_if.rvalid, (i % 8) == 3);
            check_eq("rr_ldr_rv", ldr_if.rvalid, (i % 8) == 7);
            if ((i % 8) == 3) check_eq("rr_cpu_rdata", cpu_if.rdata, 8'h11);
            if ((i % 8) == 7) check_eq("rr_ldr_rdata", ldr_if.rdata, 8'h22);
            tick(); #1;
        end
        // Requests withdrawn before the grant edge leave no trace
        cpu_if.req = 0; ldr_if.req = 0;
        #1;
        check_eq("drop_gnt", {cpu_if.gnt, ldr_if.gnt}, 0);
        tick(); #1;
        check_eq("drop_idle", cs_n, 1);

        // Reset during the strobe of a write
        ldr_if.req = 1; ldr_if.we = 1; ldr_if.addr = 14'h0005; ldr_if.wdata = 8'h77;
        #1;
        check_eq("mr_gnt", ldr_if.gnt, 1);
        tick(); ldr_if.req = 0;
        tick(); #1;
        check_eq("mr_strobe_we", we_n, 0);
        rst_n = 1'b0;
        tick(); #1;
        check_eq("mr_we", we_n, 1);
        check_eq("mr_cs", cs_n, 1);
        check_eq("mr_oe", oe_n, 1);
        check_eq("mr_doe", doe, 0);
        check_eq("mr_rv", {cpu_if.rvalid, ldr_if.rvalid}, 0);
        rst_n = 1'b1;
        tick();
        cpu_if.req = 1; cpu_if.we = 0; cpu_if.addr = 14'h0010;
        #1;
        check_eq("mr_new_gnt", cpu_if.gnt, 1);
        tick(); cpu_if.req = 0;
        tick(); tick(); #1;
        check_eq("mr_new_rv", cpu_if.rvalid, 1);
        check_eq("mr_new_rdata", cpu_if.rdata, 8'hA5);
        check_eq("mr_new_ldr_rv", ldr_if.rvalid, 0);
        tick(); #1;

        // WAIT_CYCLES=3 read
        cpu3_if.req = 1; cpu3_if.we = 0; cpu3_if.addr = 14'h0003;
        #1;
        check_eq("w3_gnt", cpu3_if.gnt, 1);
        for (int i = 1; i <= 6; i++) begin
            tick();
            if (i == 1) cpu3_if.req = 0;
            #1;
            check_eq("w3_oe", oe3_n, !(i >= 2 && i <= 4));
            check_eq("w3_we", we3_n, 1);
            check_eq("w3_rv", cpu3_if.rvalid, i == 5);
            if (i == 5) check_eq("w3_rdata", cpu3_if.rdata, 8'h3C);
        end

`ifdef SRAM_ARB_LOCK_EN
        // Loader lock: only loader grants, then CPU once released
        ldr_lock = 1'b1;
        cpu_if.req = 1; cpu_if.we = 0; cpu_if.addr = 14'h0001;
        ldr_if.req = 1; ldr_if.we = 0; ldr_if.addr = 14'h0002;
        #1;
        for (int i = 0; i < 40; i++) begin
            check_eq("lk_cpu_gnt", cpu_if.gnt, 0);
            check_eq("lk_ldr_gnt", ldr_if.gnt, (i % 4) == 0);
            tick(); #1;
        end
        ldr_lock = 1'b0;
        #1;
        check_eq("lk_rel_cpu", cpu_if.gnt, 1);
        check_eq("lk_rel_ldr", ldr_if.gnt, 0);
        tick();
        cpu_if.req = 0; ldr_if.req = 0;
        repeat (3) tick();
`endif

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
